// File: rtl/sffsrce_pipe_pkg.sv
// Shared constants and helpers for the sffsrce_pipe register pipeline.
package sffsrce_pipe_pkg;

    localparam int unsigned MODE_LOCKSTEP = 0;
    localparam int unsigned MODE_ELASTIC  = 1;

    // Width needed to hold a count from 0 to depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sffsrce_stage.sv
// One pipeline stage: data register plus valid bit.
// Priority on each edge: rst_ni > srst_i > sset_i > load_i.
module sffsrce_stage #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             srst_i,
    input  logic             sset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             vld_i,
    output logic [WIDTH-1:0] d_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (srst_i) begin
            data_d = RST_VAL;
            vld_d  = 1'b0;
        end else if (sset_i) begin
            data_d = SET_VAL;
            vld_d  = 1'b1;
        end else if (load_i) begin
            vld_d = vld_i;
            // A bubble moving in leaves the old data in place.
            if (vld_i) begin
                data_d = d_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= RST_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign d_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/sffsrce_pipe.sv
// Register pipeline with clock enable, synchronous set/clear and valid/ready
// handshake; lockstep shift or bubble-collapsing advance selected by ELASTIC.
module sffsrce_pipe
    import sffsrce_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter int unsigned      ELASTIC = MODE_LOCKSTEP
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce,
    input  logic                          sset,
    input  logic                          srst,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_vld,
    output logic                          d_rdy,
    output logic [WIDTH-1:0]              q,
    output logic                          q_vld,
    input  logic                          q_rdy,
    output logic [occ_width(DEPTH)-1:0]   occ
);

    localparam int unsigned OW = occ_width(DEPTH);

    if (DEPTH == 0) begin : g_bad_depth
        $error("sffsrce_pipe: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stg_data [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0] stg_vld;
    logic [DEPTH-1:0] src_vld;
    logic [DEPTH-1:0] load;
    logic             accept, retire;
    logic [OW-1:0]    occ_d, occ_q;

    // load[i]: stage i takes the contents of stage i-1 (or d) on this edge.
    always_comb begin : adv_chain
        logic nxt;
        nxt  = 1'b0;
        load = '0;
        if (ELASTIC == MODE_ELASTIC) begin
            nxt = q_rdy;
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                load[i] = ce & (~stg_vld[i] | nxt);
                nxt     = load[i];
            end
        end else begin
            nxt  = ce & (q_rdy | ~stg_vld[DEPTH-1]);
            load = {DEPTH{nxt}};
        end
    end

    always_comb begin
        src_data[0] = d;
        src_vld[0]  = d_vld;
        for (int i = 1; i < int'(DEPTH); i++) begin
            src_data[i] = stg_data[i-1];
            src_vld[i]  = stg_vld[i-1];
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        sffsrce_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .srst_i  (srst),
            .sset_i  (sset),
            .load_i  (load[i]),
            .d_i     (src_data[i]),
            .vld_i   (src_vld[i]),
            .d_o     (stg_data[i]),
            .vld_o   (stg_vld[i])
        );
    end

    always_comb begin
        // Words offered while reset, clear or set own the edge would be lost.
        d_rdy  = rst_n & ~srst & ~sset & load[0];
        accept = d_vld & d_rdy;
        retire = stg_vld[DEPTH-1] & q_rdy & load[DEPTH-1];
        occ_d  = occ_q;
        if (srst) begin
            occ_d = '0;
        end else if (sset) begin
            occ_d = OW'(DEPTH);
        end else if (accept & ~retire) begin
            occ_d = occ_q + 1'b1;
        end else if (retire & ~accept) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign q     = stg_data[DEPTH-1];
    assign q_vld = stg_vld[DEPTH-1];
    assign occ   = occ_q;

endmodule

// File: doc/sffsrce_pipe.md
SFFSRCE_PIPE -- requirements
Module: sffsrce_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data bit width (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of register stages (>=1; elaboration error otherwise).
REQ-003 The block SHALL have parameter RST_VAL, default all-zeros, the data value loaded by rst_n and srst.
REQ-004 The block SHALL have parameter SET_VAL, default all-ones, the data value loaded by sset.
REQ-005 The block SHALL have parameter ELASTIC, default 0: 0 = lockstep shift, 1 = bubble-collapsing.
REQ-006 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  reset, synchronous and active-low.
REQ-009 ce  input  1  clock enable.
REQ-010 sset  input  1  synchronous set of all stages.
REQ-011 srst  input  1  synchronous clear of all stages.
REQ-012 d  input  WIDTH  input data.
REQ-013 d_vld  input  1  input data valid.
REQ-014 d_rdy  output  1  input accepted this cycle when d_vld=1.
REQ-015 q  output  WIDTH  data of the last stage (DEPTH-1).
REQ-016 q_vld  output  1  valid bit of the last stage.
REQ-017 q_rdy  input  1  downstream accepts q this cycle.
REQ-018 occ  output  $clog2(DEPTH+1)  registered count of valid stages.

Function
REQ-019 Each stage i SHALL hold data[i] and valid v[i]; q = data[DEPTH-1] and q_vld = v[DEPTH-1].
REQ-020 Priority per edge SHALL be: rst_n=0 > srst > sset > ce; srst and sset act regardless of ce.
REQ-021 srst SHALL load RST_VAL into all stages, clear all v[i] and set occ=0.
REQ-022 sset (srst=0) SHALL load SET_VAL into all stages, set all v[i]=1 and set occ=DEPTH.
REQ-023 With ce=0 and no srst/sset, all state SHALL hold and d_rdy SHALL be 0.
REQ-024 ELASTIC=0: adv = ce & (q_rdy | ~q_vld); when adv, every stage SHALL take the previous stage's data/valid, stage 0 taking d/d_vld; d_rdy = adv.
REQ-025 ELASTIC=1: the last stage advances if ce & (q_rdy | ~v[DEPTH-1]); stage i<DEPTH-1 advances if ce & (~v[i+1] | stage i+1 advances); d_rdy = ce & (~v[0] | stage 0 advances).
REQ-026 A data register SHALL update only on a transfer into its stage; data of invalid stages is held, not cleared.
REQ-027 Latency SHALL be DEPTH clock edges from input acceptance to q_vld=1 through an empty, unstalled pipe.
REQ-028 occ SHALL be +1 on accept only, -1 on output transfer (q_vld & q_rdy & advance) only, unchanged on both or neither, and always equal popcount(v).
REQ-029 Full (occ=DEPTH) with simultaneous output transfer SHALL accept new input (d_rdy=1) and keep occ=DEPTH.
REQ-030 Order SHALL be preserved; no word is ever dropped or duplicated outside srst/sset/rst_n.
REQ-031 DEPTH=1 SHALL behave as a single registered stage with the same rules.

Reset
REQ-032 On a rising clk edge with rst_n=0, all data SHALL be RST_VAL, all v[i]=0, occ=0.
REQ-033 While rst_n=0, d_rdy SHALL be 0; reset mid-transfer discards all in-flight words.
REQ-034 No state SHALL change asynchronously to clk.

Structure
REQ-035 Package sffsrce_pipe_pkg SHALL hold the ELASTIC mode constants (MODE_LOCKSTEP=0, MODE_ELASTIC=1) and the occ-width function.
REQ-036 One sub-module sffsrce_stage (WIDTH data reg + valid, priority rst_n > srst > sset > load) SHALL be instantiated DEPTH times; the advance chain and occ counter live in sffsrce_pipe.

Verification (WIDTH=8, DEPTH=4)
REQ-037 Reset: rst_n=0 for 2 cycles with d_vld=1, d=0xA5 -> q=0x00, q_vld=0, occ=0, d_rdy=0.
REQ-038 Latency, ELASTIC=0, q_rdy=1: push 0x11,0x22,0x33,0x44 on consecutive cycles -> q=0x11, q_vld=1 exactly 4 edges after 0x11 is accepted, then 0x22,0x33,0x44 on successive cycles.
REQ-039 Backpressure, ELASTIC=1, q_rdy=0: offer 6 words -> 4 accepted, d_rdy=0 after the 4th, occ=4; raise q_rdy -> 0x11..0x44 emerge in order, then the two remaining words.
REQ-040 Bubble collapse, q_rdy=0: push 0x11, idle 2 cycles, push 0x22 -> ELASTIC=1: v=1 in stages 3 and 2, occ=2; ELASTIC=0 with q_rdy=1: the 2-cycle gap is preserved at q.
REQ-041 Set/clear with ce=0: sset=1 -> next edge q=0xFF, q_vld=1, occ=4; sset=1 and srst=1 together -> q=0x00, q_vld=0, occ=0.
REQ-042 Full pass-through, ELASTIC=1, occ=4, q_rdy=1, d_vld=1 -> d_rdy=1, occ stays 4, one word out and one in per cycle.
